// File: rtl/usb_rx_packet_decoder.sv
// rtl/usb_rx_packet_decoder.sv - receive-side SIE stage: PID/CRC16 check, payload to RX FIFO, handshake status
// Outputs are registered; status flags pulse together with rx_done.
module usb_rx_packet_decoder #(
   parameter int TIMEOUT_CYCLES = 18,
   parameter int MAX_PAYLOAD    = 32,
   parameter int CNT_W          = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_transfer,
   input  logic             HS_transfer,
   input  logic             rx_active,
   input  logic             rx_valid,
   input  logic             rx_error,
   input  logic [7:0]       rx_data,
   input  logic             fifo_full,
   output logic             wr_en,
   output logic [7:0]       wr_data,
   output logic             Ack,
   output logic             rx_done,
   output logic             data_pid,
   output logic [CNT_W-1:0] rx_byte_count,
   output logic             ack_rcvd,
   output logic             nak_rcvd,
   output logic             stall_rcvd,
   output logic             crc_error,
   output logic             pid_error,
   output logic             overflow,
   output logic             timeout
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_DPID, S_WAIT_HPID, S_RX_DATA, S_HS_END, S_CHECK, S_DRAIN
   } state_t;

   // Latched error kind, ordered to drop straight into the status vector
   localparam logic [2:0] ERR_CRC = 3'b100;
   localparam logic [2:0] ERR_PID = 3'b010;
   localparam logic [2:0] ERR_OVF = 3'b001;

   state_t             r_state, w_state;
   logic [TMR_W-1:0]   r_timer, w_timer;
   logic [15:0]        r_crc, w_crc;
   logic [7:0]         r_pipe_old, w_pipe_old;
   logic [7:0]         r_pipe_new, w_pipe_new;
   logic [1:0]         r_pipe_cnt, w_pipe_cnt;
   logic [CNT_W-1:0]   r_rcv_cnt, w_rcv_cnt;
   logic [CNT_W-1:0]   r_byte_cnt, w_byte_cnt;
   logic               r_data_pid, w_data_pid;
   logic [2:0]         r_hs, w_hs;
   logic [2:0]         r_err, w_err;
   logic               r_wr_en, w_wr_en;
   logic [7:0]         r_wr_data, w_wr_data;
   logic               r_ack, w_ack;
   logic               r_done, w_done;
   logic [6:0]         r_status, w_status;
   logic               w_pid_ok;
   logic               w_good;
   logic               w_ovf;

   function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return c;
   endfunction

   assign w_pid_ok = (rx_data[3:0] == ~rx_data[7:4]);
   assign w_good   = (r_rcv_cnt >= CNT_W'(2)) && (r_crc == 16'hB001);
   assign w_ovf    = rx_valid && ((r_rcv_cnt == CNT_W'(MAX_PAYLOAD + 2)) ||
                                  ((r_pipe_cnt == 2'd2) && fifo_full));

   always_comb begin
      w_state    = r_state;
      w_timer    = r_timer;
      w_crc      = r_crc;
      w_pipe_old = r_pipe_old;
      w_pipe_new = r_pipe_new;
      w_pipe_cnt = r_pipe_cnt;
      w_rcv_cnt  = r_rcv_cnt;
      w_byte_cnt = r_byte_cnt;
      w_data_pid = r_data_pid;
      w_hs       = r_hs;
      w_err      = r_err;
      w_wr_en    = 1'b0;
      w_wr_data  = r_wr_data;
      w_ack      = 1'b0;
      w_done     = 1'b0;
      w_status   = 7'b0;
      case (r_state)
         S_IDLE: begin
            if (in_transfer || HS_transfer) begin
               w_state    = in_transfer ? S_WAIT_DPID : S_WAIT_HPID;
               w_timer    = '0;
               w_crc      = 16'hFFFF;
               w_pipe_cnt = 2'd0;
               w_rcv_cnt  = '0;
               w_byte_cnt = '0;
               w_hs       = 3'b0;
               w_err      = 3'b0;
            end
         end
         S_WAIT_DPID, S_WAIT_HPID: begin
            if (rx_valid) begin
               if (r_state == S_WAIT_DPID) begin
                  if (w_pid_ok && (rx_data == 8'hC3 || rx_data == 8'h4B)) begin
                     w_state    = S_RX_DATA;
                     w_data_pid = (rx_data == 8'h4B);
                  end else begin
                     w_state = S_DRAIN;
                     w_err   = ERR_PID;
                  end
               end else begin
                  w_state = S_HS_END;
                  case (rx_data)
                     8'hD2:   w_hs = 3'b100;
                     8'h5A:   w_hs = 3'b010;
                     8'h1E:   w_hs = 3'b001;
                     default: begin
                        w_state = S_DRAIN;
                        w_err   = ERR_PID;
                     end
                  endcase
               end
            end else if (!rx_active) begin
               if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  w_state  = S_IDLE;
                  w_done   = 1'b1;
                  w_status = 7'b0000001;
               end else begin
                  w_timer = r_timer + TMR_W'(1);
               end
            end
         end
         S_RX_DATA: begin
            if (!rx_active) begin
               w_state  = S_CHECK;
               w_done   = 1'b1;
               w_ack    = w_good;
               w_status = w_good ? 7'b0 : 7'b0001000;
            end else if (w_ovf) begin
               w_state = S_DRAIN;
               w_err   = ERR_OVF;
            end else if (rx_error) begin
               w_state = S_DRAIN;
               w_err   = ERR_CRC;
            end else if (rx_valid) begin
               // Two-byte delay line: whatever is still held when the bus goes idle is the CRC
               w_crc      = f_crc16(r_crc, rx_data);
               w_rcv_cnt  = r_rcv_cnt + CNT_W'(1);
               w_pipe_old = r_pipe_new;
               w_pipe_new = rx_data;
               if (r_pipe_cnt == 2'd2) begin
                  w_wr_en    = 1'b1;
                  w_wr_data  = r_pipe_old;
                  w_byte_cnt = r_byte_cnt + CNT_W'(1);
               end else begin
                  w_pipe_cnt = r_pipe_cnt + 2'd1;
               end
            end
         end
         S_CHECK: w_state = S_IDLE;
         S_HS_END: begin
            if (rx_valid) begin
               w_state = S_DRAIN;
               w_err   = ERR_PID;
            end else if (!rx_active) begin
               w_state  = S_IDLE;
               w_done   = 1'b1;
               w_status = {r_hs, 4'b0};
            end
         end
         S_DRAIN: begin
            if (!rx_active) begin
               w_state  = S_IDLE;
               w_done   = 1'b1;
               w_status = {3'b0, r_err, 1'b0};
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_crc      <= '0;
         r_pipe_old <= '0;
         r_pipe_new <= '0;
         r_pipe_cnt <= '0;
         r_rcv_cnt  <= '0;
         r_byte_cnt <= '0;
         r_data_pid <= 1'b0;
         r_hs       <= '0;
         r_err      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= '0;
         r_ack      <= 1'b0;
         r_done     <= 1'b0;
         r_status   <= '0;
      end else begin
         r_state    <= w_state;
         r_timer    <= w_timer;
         r_crc      <= w_crc;
         r_pipe_old <= w_pipe_old;
         r_pipe_new <= w_pipe_new;
         r_pipe_cnt <= w_pipe_cnt;
         r_rcv_cnt  <= w_rcv_cnt;
         r_byte_cnt <= w_byte_cnt;
         r_data_pid <= w_data_pid;
         r_hs       <= w_hs;
         r_err      <= w_err;
         r_wr_en    <= w_wr_en;
         r_wr_data  <= w_wr_data;
         r_ack      <= w_ack;
         r_done     <= w_done;
         r_status   <= w_status;
      end
   end

   assign wr_en         = r_wr_en;
   assign wr_data       = r_wr_data;
   assign Ack           = r_ack;
   assign rx_done       = r_done;
   assign data_pid      = r_data_pid;
   assign rx_byte_count = r_byte_cnt;
   assign {ack_rcvd, nak_rcvd, stall_rcvd, crc_error, pid_error, overflow, timeout} = r_status;

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// tb/tb_usb_rx_packet_decoder.sv - self-checking bench for usb_rx_packet_decoder
// Directed table, random packets against a byte-level model, timeout and reset sequences.
module tb_usb_rx_packet_decoder;

   localparam int MAXP = 32;
   localparam logic [7:0] F_ACK = 8'h80, F_ACKR = 8'h40, F_NAK = 8'h20, F_STALL = 8'h10;
   localparam logic [7:0] F_CRC = 8'h08, F_PID = 8'h04, F_OVF = 8'h02, F_TMO = 8'h01;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       in_transfer = 1'b0, HS_transfer = 1'b0;
   logic       rx_active = 1'b0, rx_valid = 1'b0, rx_error = 1'b0, fifo_full = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       wr_en, Ack, rx_done, data_pid;
   logic [7:0] wr_data;
   logic [5:0] rx_byte_count;
   logic       ack_rcvd, nak_rcvd, stall_rcvd, crc_error, pid_error, overflow, timeout;

   usb_rx_packet_decoder #(.TIMEOUT_CYCLES(18), .MAX_PAYLOAD(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .in_transfer(in_transfer), .HS_transfer(HS_transfer),
      .rx_active(rx_active), .rx_valid(rx_valid), .rx_error(rx_error), .rx_data(rx_data),
      .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .Ack(Ack), .rx_done(rx_done),
      .data_pid(data_pid), .rx_byte_count(rx_byte_count), .ack_rcvd(ack_rcvd),
      .nak_rcvd(nak_rcvd), .stall_rcvd(stall_rcvd), .crc_error(crc_error),
      .pid_error(pid_error), .overflow(overflow), .timeout(timeout));

   always #5 clk = ~clk;

   typedef struct {
      logic       is_in;
      logic       both;
      logic [7:0] pid;
      int         n;
      logic       bad_crc;
      int         full_at;
      int         err_at;
      logic [7:0] exp_flags;
      int         exp_cnt;
   } vec_t;

   vec_t       tbl[16];
   int         n_vec = 0, n_bad = 0;
   int         wr_cnt, done_cnt;
   logic [7:0] tx_q[$];
   logic [7:0] pl_q[$];
   logic [7:0] cur_pid;

   function automatic logic [7:0] flags_now();
      return {Ack, ack_rcvd, nak_rcvd, stall_rcvd, crc_error, pid_error, overflow, timeout};
   endfunction

   function automatic logic [31:0] all_outs();
      return {7'b0, wr_en, wr_data, Ack, rx_done, data_pid, rx_byte_count, ack_rcvd,
              nak_rcvd, stall_rcvd, crc_error, pid_error, overflow, timeout};
   endfunction

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if ((r[0] ^ b[k]) == 1'b1) r = (r >> 1) ^ 16'hA001;
         else                       r = r >> 1;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      if (wr_en) wr_cnt++;
      if (rx_done) done_cnt++;
   endtask

   task automatic build(input logic is_in, input logic [7:0] pid, input int n,
                        input logic bad_crc, input logic rnd);
      logic [15:0] c;
      cur_pid = pid;
      pl_q.delete();
      tx_q.delete();
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         pl_q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
         tx_q.push_back(pl_q[i]);
         c = crc_step(c, pl_q[i]);
      end
      if (is_in) begin
         c = ~c;
         if (bad_crc) c = c ^ 16'h0100;
         tx_q.push_back(c[7:0]);
         tx_q.push_back(c[15:8]);
      end
   endtask

   // Expected outcome from the packet rules: walk bytes in arrival order
   task automatic model(input logic is_in, input int full_at, input int err_at,
                        output logic [7:0] flags, output int cnt);
      int          len;
      logic        stop;
      logic [15:0] c;
      len   = tx_q.size();
      cnt   = 0;
      flags = 8'h00;
      stop  = 1'b0;
      if (!is_in) begin
         if (len != 0)            flags = F_PID;
         else if (cur_pid == 8'hD2) flags = F_ACKR;
         else if (cur_pid == 8'h5A) flags = F_NAK;
         else if (cur_pid == 8'h1E) flags = F_STALL;
         else                     flags = F_PID;
         return;
      end
      if (cur_pid != 8'hC3 && cur_pid != 8'h4B) begin
         flags = F_PID;
         return;
      end
      for (int i = 0; i < len && !stop; i++) begin
         if (err_at == i) begin
            flags = F_CRC; stop = 1'b1;
         end else if (i >= MAXP + 2) begin
            flags = F_OVF; stop = 1'b1;
         end else if (i >= 2) begin
            if (full_at >= 0 && i - 2 >= full_at) begin
               flags = F_OVF; stop = 1'b1;
            end else begin
               cnt++;
            end
         end
      end
      if (!stop) begin
         c = 16'hFFFF;
         foreach (tx_q[i]) c = crc_step(c, tx_q[i]);
         if (err_at == len)                       flags = F_CRC;
         else if (len >= 2 && c == 16'hB001)      flags = F_ACK;
         else                                     flags = F_CRC;
      end
   endtask

   task automatic run(input string tag, input logic is_in, input logic both, input int full_at,
                      input int err_at, input logic [7:0] exp_flags, input int exp_cnt,
                      input logic rnd);
      int   len;
      logic exp_w;
      len      = tx_q.size();
      wr_cnt   = 0;
      done_cnt = 0;
      in_transfer = is_in | both;
      HS_transfer = ~is_in | both;
      step();
      in_transfer = 1'b0;
      HS_transfer = 1'b0;
      repeat (rnd ? $urandom_range(0, 4) : 1) step();
      rx_active = 1'b1;
      step();
      rx_valid = 1'b1; rx_data = cur_pid;
      step();
      rx_valid = 1'b0;
      for (int i = 0; i < len; i++) begin
         if (i == err_at) begin
            rx_error = 1'b1; step(); rx_error = 1'b0;
         end
         if (rnd && ($urandom % 4 == 0)) step();
         fifo_full = (full_at >= 0) && (i - 2 >= full_at);
         rx_valid = 1'b1; rx_data = tx_q[i];
         step();
         rx_valid = 1'b0;
         exp_w = is_in && (i >= 2) && (i - 2 < exp_cnt);
         chk({tag, " wr_en"}, 32'(wr_en), 32'(exp_w));
         if (exp_w) chk({tag, " wr_data"}, 32'(wr_data), 32'(pl_q[i - 2]));
      end
      if (err_at == len) begin
         rx_error = 1'b1; step(); rx_error = 1'b0;
      end
      fifo_full = 1'b0;
      chk({tag, " early_done"}, 32'(done_cnt), 32'd0);
      rx_active = 1'b0;
      step();
      chk({tag, " rx_done"}, 32'(rx_done), 32'd1);
      chk({tag, " flags"}, 32'(flags_now()), 32'(exp_flags));
      if (is_in) begin
         chk({tag, " byte_count"}, 32'(rx_byte_count), 32'(exp_cnt));
         if (exp_flags != F_PID) chk({tag, " data_pid"}, 32'(data_pid), 32'(cur_pid == 8'h4B));
      end
      step();
      chk({tag, " done_pulse"}, 32'(rx_done), 32'd0);
      chk({tag, " wr_total"}, 32'(wr_cnt), 32'(exp_cnt));
   endtask

   initial begin
      logic [7:0] ef;
      int         ec, n, fa, ea;
      logic       ii;
      logic [7:0] pid;

      tbl[0]  = '{1'b1, 1'b0, 8'h4B, 4,  1'b0, -1, -1, F_ACK,   4};
      tbl[1]  = '{1'b1, 1'b0, 8'hC3, 32, 1'b1, -1, -1, F_CRC,   32};
      tbl[2]  = '{1'b1, 1'b0, 8'hC3, 0,  1'b0, -1, -1, F_ACK,   0};
      tbl[3]  = '{1'b1, 1'b1, 8'h4B, 3,  1'b0, -1, -1, F_ACK,   3};
      tbl[4]  = '{1'b0, 1'b0, 8'hD2, 0,  1'b0, -1, -1, F_ACKR,  0};
      tbl[5]  = '{1'b0, 1'b0, 8'h5A, 0,  1'b0, -1, -1, F_NAK,   0};
      tbl[6]  = '{1'b0, 1'b0, 8'h1E, 0,  1'b0, -1, -1, F_STALL, 0};
      tbl[7]  = '{1'b0, 1'b0, 8'hA5, 0,  1'b0, -1, -1, F_PID,   0};
      tbl[8]  = '{1'b0, 1'b0, 8'h5B, 0,  1'b0, -1, -1, F_PID,   0};
      tbl[9]  = '{1'b0, 1'b0, 8'h5A, 1,  1'b0, -1, -1, F_PID,   0};
      tbl[10] = '{1'b1, 1'b0, 8'hD2, 4,  1'b0, -1, -1, F_PID,   0};
      tbl[11] = '{1'b1, 1'b0, 8'h4B, 6,  1'b0, 2,  -1, F_OVF,   2};
      tbl[12] = '{1'b1, 1'b0, 8'hC3, 33, 1'b0, -1, -1, F_OVF,   32};
      tbl[13] = '{1'b1, 1'b0, 8'hC3, 5,  1'b0, -1, 3,  F_CRC,   1};
      tbl[14] = '{1'b1, 1'b0, 8'h4B, 32, 1'b0, -1, -1, F_ACK,   32};
      tbl[15] = '{1'b1, 1'b0, 8'h4B, 2,  1'b0, -1, 4,  F_CRC,   2};

      repeat (3) @(negedge clk);
      chk("reset_state", all_outs(), 32'd0);
      reset = 1'b1;
      step();

      foreach (tbl[t]) begin
         build(tbl[t].is_in, tbl[t].pid, tbl[t].n, tbl[t].bad_crc, 1'b0);
         run($sformatf("tbl%0d", t), tbl[t].is_in, tbl[t].both, tbl[t].full_at,
             tbl[t].err_at, tbl[t].exp_flags, tbl[t].exp_cnt, 1'b0);
      end

      // Timeout: rx_done lands exactly 18 cycles after the arm edge
      in_transfer = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_transfer = 1'b0;
      for (int c = 0; c <= 18; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("timeout_c%0d rx_done", c), 32'(rx_done), 32'(c == 18));
      end
      chk("timeout flags", 32'(flags_now()), 32'(F_TMO));
      step();

      // Reset pulled in the middle of a data packet
      build(1'b1, 8'h4B, 8, 1'b0, 1'b0);
      in_transfer = 1'b1; step(); in_transfer = 1'b0;
      rx_active = 1'b1; step();
      rx_valid = 1'b1; rx_data = cur_pid; step();
      for (int i = 0; i < 4; i++) begin
         rx_data = tx_q[i]; step();
      end
      reset = 1'b0;
      rx_valid = 1'b0; rx_active = 1'b0;
      #1;
      chk("reset_mid outs", all_outs(), 32'd0);
      step();
      step();
      chk("reset_hold outs", all_outs(), 32'd0);
      reset = 1'b1;
      step();
      build(1'b1, 8'h4B, 4, 1'b0, 1'b0);
      run("post_reset", 1'b1, 1'b0, -1, -1, F_ACK, 4, 1'b0);

      for (int r = 0; r < 40; r++) begin
         ii = ($urandom % 4) != 0;
         if (ii) begin
            case ($urandom % 6)
               0, 2:    pid = 8'hC3;
               1, 3:    pid = 8'h4B;
               4:       pid = 8'hD2;
               default: pid = 8'h5B;
            endcase
            n = $urandom_range(0, 35);
         end else begin
            case ($urandom % 6)
               0:       pid = 8'hD2;
               1:       pid = 8'h5A;
               2:       pid = 8'h1E;
               3:       pid = 8'hA5;
               4:       pid = 8'h5B;
               default: pid = 8'h4B;
            endcase
            n = ($urandom % 4 == 0) ? 1 : 0;
         end
         build(ii, pid, n, ($urandom % 5) == 0, 1'b1);
         fa = (ii && ($urandom % 5 == 0)) ? $urandom_range(0, 30) : -1;
         ea = (ii && ($urandom % 6 == 0)) ? $urandom_range(0, n + 2) : -1;
         model(ii, fa, ea, ef, ec);
         run($sformatf("rnd%0d", r), ii, 1'b0, fa, ea, ef, ec, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
